// File: rtl/controlador_venda_pkg.sv
// Shared types and constants for the drink-vending transaction sequencer.
package controlador_venda_pkg;

  localparam int CRED_W = 5;

  typedef enum logic [2:0] {
    OCIOSO,
    CREDITO,
    VERIFICA,
    DISPENSA,
    TROCO,
    ERRO
  } estado_t;

  typedef enum logic [1:0] {
    MODO_BRANCO  = 2'd0,
    MODO_CREDITO = 2'd1,
    MODO_BEBIDA  = 2'd2,
    MODO_ERRO    = 2'd3
  } modo_t;

  // Index of the set bit of a one-hot drink-button vector.
  function automatic logic [1:0] indice_oh(input logic [3:0] v);
    indice_oh = 2'd0;
    for (int i = 0; i < 4; i++)
      if (v[i]) indice_oh = 2'(i);
  endfunction

endpackage

// File: rtl/controlador_venda_if.sv
// Event inputs and display/dispense outputs of the vending sequencer.
interface controlador_venda_if;

  logic [2:0]                              cedula;
  logic [3:0]                              botao;
  logic                                    cancel;
  logic                                    v_sense;
  logic [controlador_venda_pkg::CRED_W-1:0] credito;
  logic [1:0]                              bebida_sel;
  logic [1:0]                              modo_display;
  logic                                    dispensa;
  logic [controlador_venda_pkg::CRED_W-1:0] troco;
  logic                                    troco_valido;
  logic                                    rejeita;
  logic                                    insuficiente;
  logic                                    led_verde;
  logic                                    led_vermelho;
  logic                                    led_azul;

  modport master (
    output cedula, botao, cancel, v_sense,
    input  credito, bebida_sel, modo_display, dispensa, troco, troco_valido,
           rejeita, insuficiente, led_verde, led_vermelho, led_azul
  );

  modport slave (
    input  cedula, botao, cancel, v_sense,
    output credito, bebida_sel, modo_display, dispensa, troco, troco_valido,
           rejeita, insuficiente, led_verde, led_vermelho, led_azul
  );

endinterface

// File: rtl/controlador_venda_temporizador.sv
// Clearable saturating cycle counter with a terminal-count flag.
module temporizador #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] contagem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 contagem <= '0;
    else if (clr)              contagem <= '0;
    else if (contagem != '1)   contagem <= contagem + 1'b1;
  end

  assign fim = (contagem == limite);

endmodule

// File: rtl/controlador_venda.sv
// Vending transaction sequencer: credit accumulation, price check, dispense,
// change, cancel/timeout and fault handling.
module controlador_venda
  import controlador_venda_pkg::*;
#(
  parameter int VALOR_C0       = 1,
  parameter int VALOR_C1       = 2,
  parameter int VALOR_C2       = 5,
  parameter int PRECO0         = 3,
  parameter int PRECO1         = 4,
  parameter int PRECO2         = 5,
  parameter int PRECO3         = 7,
  parameter int CREDITO_MAX    = 20,
  parameter int DISP_CICLOS    = 50,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic                clk,
  input logic                reset,
  controlador_venda_if.slave bus
);

  localparam int TMAX = (TIMEOUT_CICLOS > DISP_CICLOS) ? TIMEOUT_CICLOS : DISP_CICLOS;
  localparam int TW   = $clog2(TMAX);

  estado_t           estado, prox;
  logic [CRED_W-1:0] credito_q, troco_q, valor, preco;
  logic [CRED_W:0]   soma;
  logic [1:0]        sel_q;
  logic              insuf_q, rejeita_q;
  logic              ced_ok, bot_ok, cabe, tempo_fim;
  logic              carrega, rejeita_d, trava_sel, desconta, insuf_set, reinicia;

  assign ced_ok = $onehot(bus.cedula);
  assign bot_ok = $onehot(bus.botao);

  always_comb begin
    valor = '0;
    case (bus.cedula)
      3'b001:  valor = CRED_W'(VALOR_C0);
      3'b010:  valor = CRED_W'(VALOR_C1);
      3'b100:  valor = CRED_W'(VALOR_C2);
      default: valor = '0;
    endcase
  end

  always_comb begin
    case (sel_q)
      2'd0:    preco = CRED_W'(PRECO0);
      2'd1:    preco = CRED_W'(PRECO1);
      2'd2:    preco = CRED_W'(PRECO2);
      default: preco = CRED_W'(PRECO3);
    endcase
  end

  // Sum one bit wider so an over-limit note can never wrap into range.
  assign soma = {1'b0, credito_q} + {1'b0, valor};
  assign cabe = (soma <= (CRED_W+1)'(CREDITO_MAX));

  // One counter serves both the CREDITO inactivity timeout and the dispense hold.
  temporizador #(.W(TW)) u_tempo (
    .clk    (clk),
    .reset  (reset),
    .clr    ((prox != estado) || reinicia),
    .limite (TW'((estado == DISPENSA) ? DISP_CICLOS - 1 : TIMEOUT_CICLOS - 1)),
    .fim    (tempo_fim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox;
  end

  always_comb begin
    prox      = estado;
    carrega   = 1'b0;
    rejeita_d = 1'b0;
    trava_sel = 1'b0;
    desconta  = 1'b0;
    insuf_set = 1'b0;
    reinicia  = 1'b0;
    case (estado)
      OCIOSO:
        if (bus.v_sense) prox = ERRO;
        else if (!bus.cancel && ced_ok) begin
          carrega = 1'b1;
          prox    = CREDITO;
        end
      CREDITO:
        if (bus.v_sense) prox = ERRO;
        else if (bus.cancel || tempo_fim) prox = TROCO;
        else if (ced_ok) begin
          if (cabe) begin
            carrega  = 1'b1;
            reinicia = 1'b1;
          end else rejeita_d = 1'b1;
        end else if (bot_ok) begin
          trava_sel = 1'b1;
          prox      = VERIFICA;
        end
      VERIFICA:
        if (bus.v_sense) prox = ERRO;
        else if (credito_q >= preco) begin
          desconta = 1'b1;
          prox     = DISPENSA;
        end else begin
          insuf_set = 1'b1;
          prox      = CREDITO;
        end
      // A fault seen mid-dispense is acted on only once the hold completes.
      DISPENSA:
        if (tempo_fim)
          prox = bus.v_sense ? ERRO : ((credito_q != '0) ? TROCO : OCIOSO);
      TROCO:
        prox = bus.v_sense ? ERRO : OCIOSO;
      ERRO:
        if (!bus.v_sense) prox = (credito_q != '0) ? TROCO : OCIOSO;
      default:
        prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credito_q <= '0;
      troco_q   <= '0;
      sel_q     <= '0;
      insuf_q   <= 1'b0;
      rejeita_q <= 1'b0;
    end else begin
      rejeita_q <= rejeita_d;
      if (estado == TROCO) begin
        troco_q   <= credito_q;
        credito_q <= '0;
      end else if (carrega)  credito_q <= soma[CRED_W-1:0];
      else if (desconta)     credito_q <= credito_q - preco;
      if (trava_sel) sel_q <= indice_oh(bus.botao);
      if (carrega)        insuf_q <= 1'b0;
      else if (insuf_set) insuf_q <= 1'b1;
    end
  end

  always_comb begin
    bus.modo_display = MODO_BRANCO;
    bus.dispensa     = 1'b0;
    bus.led_verde    = 1'b0;
    bus.led_vermelho = 1'b0;
    case (estado)
      OCIOSO:   bus.led_verde = 1'b1;
      CREDITO: begin
        bus.modo_display = MODO_CREDITO;
        bus.led_vermelho = 1'b1;
      end
      VERIFICA: bus.modo_display = MODO_BEBIDA;
      DISPENSA: begin
        bus.modo_display = MODO_BEBIDA;
        bus.dispensa     = 1'b1;
      end
      TROCO:    bus.modo_display = MODO_CREDITO;
      ERRO:     bus.modo_display = MODO_ERRO;
      default:  bus.modo_display = MODO_BRANCO;
    endcase
  end

  assign bus.credito      = credito_q;
  assign bus.bebida_sel   = sel_q;
  assign bus.troco_valido = (estado == TROCO);
  assign bus.troco        = (estado == TROCO) ? credito_q : troco_q;
  assign bus.rejeita      = rejeita_q;
  assign bus.insuficiente = insuf_q;
  assign bus.led_azul     = (estado == ERRO) || insuf_q;

endmodule
